pcie_ep_completer: RTL and testbench

Endpoint-side completer for the simplified PCIe request/completion channel. It accepts Memory Read/Write request TLPs from the host on the req_* handshake and executes them against an internal BAR-mapped register memory. It returns a completion TLP on the cpl_* handshake for every non-posted request. It sits behind the endpoint port of the PCIe interface as the device under test's target logic.

---
 rtl/pcie_tlp_pkg.sv | 40 ++++
 rtl/pcie_ep_bar_mem.sv | 38 +++
 rtl/pcie_ep_completer.sv | 152 +++++++++++++++
 tb/tb_pcie_ep_completer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pcie_tlp_pkg.sv
// rtl/pcie_tlp_pkg.sv - TLP type/status constants, field positions and packed request/completion layouts
package pcie_tlp_pkg;

   localparam logic [7:0] TLP_MRD  = 8'h00;
   localparam logic [7:0] TLP_MWR  = 8'h40;
   localparam logic [7:0] TLP_CPL  = 8'h0A;
   localparam logic [7:0] TLP_CPLD = 8'h4A;

   localparam logic [2:0] CPL_SC = 3'b000;
   localparam logic [2:0] CPL_UR = 3'b001;

   // Least-significant bit of each TLP field
   localparam int TLP_TYPE_LSB = 120;
   localparam int TLP_TAG_LSB  = 112;
   localparam int TLP_RID_LSB  = 96;
   localparam int TLP_ADDR_LSB = 64;
   localparam int TLP_STAT_LSB = 93;
   localparam int TLP_BE_LSB   = 32;
   localparam int TLP_DATA_LSB = 0;

   typedef struct packed {
      logic [7:0]  tlp_type;
      logic [7:0]  tag;
      logic [15:0] req_id;
      logic [31:0] addr;
      logic [27:0] rsvd;
      logic [3:0]  be;
      logic [31:0] data;
   } req_tlp_t;

   typedef struct packed {
      logic [7:0]  tlp_type;
      logic [7:0]  tag;
      logic [15:0] req_id;
      logic [2:0]  status;
      logic [60:0] rsvd;
      logic [31:0] data;
   } cpl_tlp_t;

endpackage

// File: rtl/pcie_ep_bar_mem.sv
// rtl/pcie_ep_bar_mem.sv - BAR register memory, byte-enabled write, registered read, synchronous clear
module pcie_ep_bar_mem #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [3:0]    i_wbe,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   // Clear every word on reset, otherwise merge the enabled bytes of a write
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wbe[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   // One-cycle synchronous read
   always_ff @(posedge i_clk) begin
      if (i_rst) r_rdata <= '0;
      else       r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pcie_ep_completer.sv
// rtl/pcie_ep_completer.sv - Endpoint completer: MRd/MWr decode, FSM, completion generation, statistics
module pcie_ep_completer
   import pcie_tlp_pkg::*;
#(
   parameter int          DEPTH    = 64,
   parameter logic [31:0] BAR_BASE = 32'h0000_1000,
   parameter int          CNT_W    = 16
) (
   input  logic             PCIE_CLK,
   input  logic             PCIE_RST,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [127:0]     req_tlp,
   output logic             cpl_valid,
   input  logic             cpl_ready,
   output logic [127:0]     cpl_tlp,
   output logic [CNT_W-1:0] stat_wr_cnt,
   output logic [CNT_W-1:0] stat_rd_cnt,
   output logic [CNT_W-1:0] stat_err_cnt
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [31:0] BAR_SIZE = 32'(DEPTH * 4);

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_CPL} state_t;

   state_t          r_state, w_next;
   req_tlp_t        w_req;
   cpl_tlp_t        w_cpl;
   logic [31:0]     w_offset;
   logic            w_addr_good, w_is_mrd, w_is_mwr;
   logic            w_hs_req, w_hs_cpl, w_mem_we;
   logic [AW-1:0]   w_idx;
   logic [31:0]     w_rdata;
   logic            w_unused_bits;

   logic [7:0]      r_tag;
   logic [15:0]     r_rid;
   logic [AW-1:0]   r_idx;
   logic            r_ur;
   logic            r_cpl_valid;
   logic [127:0]    r_cpl_tlp;
   logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt, r_err_cnt;

   assign w_req       = req_tlp;
   assign w_offset    = w_req.addr - BAR_BASE;
   assign w_addr_good = (w_req.addr >= BAR_BASE) && (w_offset < BAR_SIZE) && (w_req.addr[1:0] == 2'b00);
   assign w_idx       = w_offset[AW+1:2];
   assign w_is_mrd    = (w_req.tlp_type == TLP_MRD);
   assign w_is_mwr    = (w_req.tlp_type == TLP_MWR);
   assign w_hs_req    = req_valid && req_ready;
   assign w_hs_cpl    = r_cpl_valid && cpl_ready;
   assign w_mem_we    = w_hs_req && w_is_mwr && w_addr_good;
   assign w_unused_bits = ^{w_req.rsvd, w_offset[31:AW+2], w_offset[1:0]};

   pcie_ep_bar_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .i_clk   (PCIE_CLK),
      .i_rst   (PCIE_RST),
      .i_we    (w_mem_we),
      .i_waddr (w_idx),
      .i_wbe   (w_req.be),
      .i_wdata (w_req.data),
      .i_raddr (r_idx),
      .o_rdata (w_rdata)
   );

   // State register
   always_ff @(posedge PCIE_CLK) begin
      if (PCIE_RST) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Next state; ready depends only on the state so it never loops back from req_valid
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (w_hs_req && !w_is_mwr) w_next = ST_RD;
         end
         ST_RD:   w_next = ST_CPL;
         ST_CPL:  if (w_hs_cpl) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Capture header of a non-posted request; UR covers bad MRd and unknown types
   always_ff @(posedge PCIE_CLK) begin
      if (PCIE_RST) begin
         r_tag <= '0;
         r_rid <= '0;
         r_idx <= '0;
         r_ur  <= 1'b0;
      end else if (w_hs_req && !w_is_mwr) begin
         r_tag <= w_req.tag;
         r_rid <= w_req.req_id;
         r_idx <= w_idx;
         r_ur  <= !(w_is_mrd && w_addr_good);
      end
   end

   // Completion fields assembled from captured header and memory read data
   always_comb begin
      w_cpl        = '0;
      w_cpl.tag    = r_tag;
      w_cpl.req_id = r_rid;
      if (r_ur) begin
         w_cpl.tlp_type = TLP_CPL;
         w_cpl.status   = CPL_UR;
      end else begin
         w_cpl.tlp_type = TLP_CPLD;
         w_cpl.status   = CPL_SC;
         w_cpl.data     = w_rdata;
      end
   end

   // Completion register loads once the read data has settled, holds until accepted
   always_ff @(posedge PCIE_CLK) begin
      if (PCIE_RST) begin
         r_cpl_valid <= 1'b0;
         r_cpl_tlp   <= '0;
      end else if (r_state == ST_CPL && !r_cpl_valid) begin
         r_cpl_valid <= 1'b1;
         r_cpl_tlp   <= w_cpl;
      end else if (w_hs_cpl) begin
         r_cpl_valid <= 1'b0;
         r_cpl_tlp   <= '0;
      end
   end

   // Saturating statistics counters
   always_ff @(posedge PCIE_CLK) begin
      if (PCIE_RST) begin
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
         r_err_cnt <= '0;
      end else begin
         if (w_mem_we && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
         if (w_hs_cpl && !r_ur && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
         if (((w_hs_req && w_is_mwr && !w_addr_good) || (w_hs_cpl && r_ur)) && r_err_cnt != '1)
            r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign cpl_valid    = r_cpl_valid;
   assign cpl_tlp      = r_cpl_tlp;
   assign stat_wr_cnt  = r_wr_cnt;
   assign stat_rd_cnt  = r_rd_cnt;
   assign stat_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_pcie_ep_completer.sv
// tb/tb_pcie_ep_completer.sv - Directed self-checking bench for pcie_ep_completer
module tb_pcie_ep_completer;

   localparam int CNT_W = 3;

   logic             PCIE_CLK = 1'b0;
   logic             PCIE_RST = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [127:0]     req_tlp = '0;
   logic             cpl_valid;
   logic             cpl_ready = 1'b0;
   logic [127:0]     cpl_tlp;
   logic [CNT_W-1:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pcie_ep_completer #(.DEPTH(64), .BAR_BASE(32'h0000_1000), .CNT_W(CNT_W)) dut (
      .PCIE_CLK     (PCIE_CLK),
      .PCIE_RST     (PCIE_RST),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_tlp      (req_tlp),
      .cpl_valid    (cpl_valid),
      .cpl_ready    (cpl_ready),
      .cpl_tlp      (cpl_tlp),
      .stat_wr_cnt  (stat_wr_cnt),
      .stat_rd_cnt  (stat_rd_cnt),
      .stat_err_cnt (stat_err_cnt)
   );

   always #5 PCIE_CLK = ~PCIE_CLK;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] mk_req(input logic [7:0] t, input logic [7:0] tag,
                                          input logic [15:0] rid, input logic [31:0] addr,
                                          input logic [3:0] be, input logic [31:0] data);
      return {t, tag, rid, addr, 28'h0, be, data};
   endfunction

   function automatic logic [127:0] mk_cpl(input logic [7:0] t, input logic [7:0] tag,
                                          input logic [15:0] rid, input logic [2:0] st,
                                          input logic [31:0] data);
      return {t, tag, rid, st, 61'h0, data};
   endfunction

   // Present a request and hold it until handshaken; returns #1 after the accept edge
   task automatic send_req(input logic [127:0] tlp);
      int n;
      n = 0;
      req_tlp   = tlp;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         @(negedge PCIE_CLK);
         n++;
      end
      check_eq("req_accept_timeout", 128'(n < 50), 128'd1);
      @(posedge PCIE_CLK);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!cpl_valid && lat < 20) begin
         @(posedge PCIE_CLK);
         #1;
         lat++;
      end
   endtask

   task automatic take_cpl(output logic [127:0] tlp, output int lat);
      wait_valid(lat);
      tlp = cpl_tlp;
      cpl_ready = 1'b1;
      @(posedge PCIE_CLK);
      #1;
      cpl_ready = 1'b0;
   endtask

   task automatic expect_no_cpl(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge PCIE_CLK);
         #1;
         seen = seen | cpl_valid;
      end
      check_eq(tag, 128'(seen), 128'd0);
   endtask

   task automatic read_check(input string tag, input logic [7:0] t, input logic [7:0] rtag,
                             input logic [31:0] addr, input logic [127:0] exp);
      logic [127:0] got;
      int lat;
      send_req(mk_req(t, rtag, 16'h0100, addr, 4'h0, 32'h0));
      take_cpl(got, lat);
      check_eq({tag, "_lat"}, 128'(lat), 128'd2);
      check_eq(tag, got, exp);
   endtask

   initial begin
      logic [127:0] got, held;
      logic         bad;
      int           lat;

      repeat (3) @(posedge PCIE_CLK);
      #1;
      PCIE_RST = 1'b0;
      check_eq("rst_req_ready", 128'(req_ready), 128'd1);
      check_eq("rst_cpl_valid", 128'(cpl_valid), 128'd0);
      check_eq("rst_cpl_tlp", cpl_tlp, 128'd0);
      check_eq("rst_counters", 128'({stat_wr_cnt, stat_rd_cnt, stat_err_cnt}), 128'd0);

      // Write then read
      send_req(mk_req(8'h40, 8'h05, 16'h0100, 32'h1004, 4'hF, 32'hDEADBEEF));
      expect_no_cpl("mwr_no_cpl");
      read_check("rd_1004", 8'h00, 8'h06, 32'h1004, mk_cpl(8'h4A, 8'h06, 16'h0100, 3'b000, 32'hDEADBEEF));
      check_eq("wr_cnt_1", 128'(stat_wr_cnt), 128'd1);
      check_eq("rd_cnt_1", 128'(stat_rd_cnt), 128'd1);

      // Partial byte write
      send_req(mk_req(8'h40, 8'h01, 16'h0100, 32'h1008, 4'hF, 32'h11223344));
      send_req(mk_req(8'h40, 8'h02, 16'h0100, 32'h1008, 4'b0101, 32'hAABBCCDD));
      read_check("rd_be", 8'h00, 8'h07, 32'h1008, mk_cpl(8'h4A, 8'h07, 16'h0100, 3'b000, 32'h11BB33DD));

      // Out of range and misaligned
      read_check("rd_below", 8'h00, 8'h10, 32'h0FFC, mk_cpl(8'h0A, 8'h10, 16'h0100, 3'b001, 32'h0));
      read_check("rd_misal", 8'h00, 8'h11, 32'h1002, mk_cpl(8'h0A, 8'h11, 16'h0100, 3'b001, 32'h0));
      send_req(mk_req(8'h40, 8'h12, 16'h0100, 32'h1100, 4'hF, 32'h12345678));
      expect_no_cpl("mwr_oor_no_cpl");
      read_check("rd_alias_1000", 8'h00, 8'h13, 32'h1000, mk_cpl(8'h4A, 8'h13, 16'h0100, 3'b000, 32'h0));
      check_eq("err_cnt_3", 128'(stat_err_cnt), 128'd3);

      // Last word of the window
      send_req(mk_req(8'h40, 8'h14, 16'h0100, 32'h10FC, 4'hF, 32'hCAFEF00D));
      read_check("rd_10fc", 8'h00, 8'h15, 32'h10FC, mk_cpl(8'h4A, 8'h15, 16'h0100, 3'b000, 32'hCAFEF00D));

      // Backpressure with a second request pending upstream
      send_req(mk_req(8'h00, 8'h20, 16'h0100, 32'h1004, 4'h0, 32'h0));
      wait_valid(lat);
      check_eq("bp_lat", 128'(lat), 128'd2);
      held = cpl_tlp;
      check_eq("bp_tlp", held, mk_cpl(8'h4A, 8'h20, 16'h0100, 3'b000, 32'hDEADBEEF));
      req_tlp   = mk_req(8'h00, 8'h21, 16'h0100, 32'h1008, 4'h0, 32'h0);
      req_valid = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge PCIE_CLK);
         #1;
         if (!cpl_valid || cpl_tlp !== held || req_ready) bad = 1'b1;
      end
      check_eq("bp_stall_stable", 128'(bad), 128'd0);
      cpl_ready = 1'b1;
      @(posedge PCIE_CLK);
      #1;
      cpl_ready = 1'b0;
      check_eq("bp_after_hs_ready", 128'({req_ready, cpl_valid}), 128'b10);
      @(posedge PCIE_CLK);
      #1;
      req_valid = 1'b0;
      check_eq("bp_second_accepted", 128'(req_ready), 128'd0);
      take_cpl(got, lat);
      check_eq("bp_second_lat", 128'(lat), 128'd2);
      check_eq("bp_second_tlp", got, mk_cpl(8'h4A, 8'h21, 16'h0100, 3'b000, 32'h11BB33DD));

      // Unsupported type
      send_req(mk_req(8'h20, 8'h7F, 16'h0300, 32'h1004, 4'hF, 32'h0));
      take_cpl(got, lat);
      check_eq("unsup_tlp", got, mk_cpl(8'h0A, 8'h7F, 16'h0300, 3'b001, 32'h0));
      check_eq("err_cnt_4", 128'(stat_err_cnt), 128'd4);

      // Error counter saturation
      for (int i = 0; i < 9; i++) send_req(mk_req(8'h40, 8'h00, 16'h0, 32'h2000, 4'hF, 32'hFFFFFFFF));
      check_eq("cnt_sat", 128'({stat_wr_cnt, stat_rd_cnt, stat_err_cnt}), 128'({3'd4, 3'd6, 3'd7}));

      // Reset while a completion is pending
      send_req(mk_req(8'h00, 8'h30, 16'h0100, 32'h1004, 4'h0, 32'h0));
      wait_valid(lat);
      check_eq("rst_mid_valid", 128'(cpl_valid), 128'd1);
      PCIE_RST = 1'b1;
      @(posedge PCIE_CLK);
      #1;
      check_eq("rst_mid_cpl", {127'(cpl_tlp[126:0]), cpl_valid}, 128'd0);
      check_eq("rst_mid_cnt", 128'({stat_wr_cnt, stat_rd_cnt, stat_err_cnt}), 128'd0);
      PCIE_RST = 1'b0;
      @(posedge PCIE_CLK);
      #1;
      check_eq("rst_rel_ready", 128'({req_ready, cpl_valid}), 128'b10);
      read_check("rd_after_rst", 8'h00, 8'h31, 32'h1004, mk_cpl(8'h4A, 8'h31, 16'h0100, 3'b000, 32'h0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
